sch_issue_queue: RTL and testbench

- Scheduling-stage consumer of the decode/rename-to-schedule pipeline register.
- Accepts one renamed instruction per cycle into a collapsing issue queue and tracks physical-register readiness in a scoreboard.
- Issues the oldest instruction whose operands are ready to the execute stage through a valid/ready handshake.
- Drives back-pressure (stall) toward hazard control.

---
 rtl/sch_issue_queue.sv | 179 +++++++++++++++++
 tb/tb_sch_issue_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sch_issue_queue.sv
// Collapsing issue queue with physical-register scoreboard; oldest-ready select.
// Define SCH_WAKEUP_BYPASS_EN to let select see same-cycle writeback wakeups.
module sch_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_stall,
  input  logic                       i_src1_used,
  input  logic                       i_src2_used,
  input  logic                       i_dst_used,
  input  logic [PREG_W-1:0]          i_src1_preg,
  input  logic [PREG_W-1:0]          i_src2_preg,
  input  logic [PREG_W-1:0]          i_dst_preg,
  input  logic [PAYLOAD_W-1:0]       i_payload,
  input  logic                       i_wb_valid,
  input  logic [PREG_W-1:0]          i_wb_preg,
  output logic                       o_issue_valid,
  input  logic                       i_issue_ready,
  output logic [PREG_W-1:0]          o_issue_src1_preg,
  output logic [PREG_W-1:0]          o_issue_src2_preg,
  output logic [PREG_W-1:0]          o_issue_dst_preg,
  output logic                       o_issue_dst_used,
  output logic [PAYLOAD_W-1:0]       o_issue_payload,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned NPREG = 2 ** PREG_W;

  logic [CW-1:0]        count_q, count_d;
  logic [NPREG-1:0]     sb_q, sb_d;
  logic [DEPTH-1:0]     s1r_q, s1r_d, s2r_q, s2r_d, du_q, du_d;
  logic [PREG_W-1:0]    s1p_q [DEPTH];
  logic [PREG_W-1:0]    s1p_d [DEPTH];
  logic [PREG_W-1:0]    s2p_q [DEPTH];
  logic [PREG_W-1:0]    s2p_d [DEPTH];
  logic [PREG_W-1:0]    dp_q  [DEPTH];
  logic [PREG_W-1:0]    dp_d  [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q  [DEPTH];
  logic [PAYLOAD_W-1:0] pl_d  [DEPTH];

  logic [DEPTH-1:0] valid, rdy1, rdy2, cand;
  logic [IW-1:0]    sel;
  logic             found;
  logic             issue_fire, disp_fire;
  logic [CW-1:0]    wr_slot;
  logic             cap1, cap2;

  always_comb begin
    valid = '0;
    rdy1  = '0;
    rdy2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(i) < count_q);
      rdy1[i]  = s1r_q[i];
      rdy2[i]  = s2r_q[i];
`ifdef SCH_WAKEUP_BYPASS_EN
      rdy1[i]  = rdy1[i] | (i_wb_valid && (s1p_q[i] == i_wb_preg));
      rdy2[i]  = rdy2[i] | (i_wb_valid && (s2p_q[i] == i_wb_preg));
`endif
    end
    cand = valid & rdy1 & rdy2;
  end

  // Oldest ready entry; falls back to slot 0 when nothing is ready.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && !found) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign o_issue_valid     = |cand;
  assign o_issue_src1_preg = s1p_q[sel];
  assign o_issue_src2_preg = s2p_q[sel];
  assign o_issue_dst_preg  = dp_q[sel];
  assign o_issue_dst_used  = du_q[sel];
  assign o_issue_payload   = pl_q[sel];
  assign o_count           = count_q;
  assign o_stall           = (count_q == CW'(DEPTH));

  assign issue_fire = o_issue_valid && i_issue_ready && !i_flush;
  assign disp_fire  = i_valid && !o_stall && !i_flush;
  assign wr_slot    = count_q - CW'(issue_fire);

  // Writeback match at capture closes the gap between scoreboard read and update.
  assign cap1 = !i_src1_used || (i_src1_preg == '0) || sb_q[i_src1_preg] ||
                (i_wb_valid && (i_wb_preg == i_src1_preg));
  assign cap2 = !i_src2_used || (i_src2_preg == '0) || sb_q[i_src2_preg] ||
                (i_wb_valid && (i_wb_preg == i_src2_preg));

  always_comb begin
    int unsigned j;
    j       = 0;
    s1r_d   = s1r_q;
    s2r_d   = s2r_q;
    du_d    = du_q;
    s1p_d   = s1p_q;
    s2p_d   = s2p_q;
    dp_d    = dp_q;
    pl_d    = pl_q;
    for (int i = 0; i < DEPTH; i++) begin
      j = (issue_fire && (i >= int'(sel))) ? i + 1 : i;
      if (j < DEPTH) begin
        s1r_d[i] = s1r_q[j];
        s2r_d[i] = s2r_q[j];
        du_d[i]  = du_q[j];
        s1p_d[i] = s1p_q[j];
        s2p_d[i] = s2p_q[j];
        dp_d[i]  = dp_q[j];
        pl_d[i]  = pl_q[j];
      end
      if (i_wb_valid && (s1p_d[i] == i_wb_preg)) s1r_d[i] = 1'b1;
      if (i_wb_valid && (s2p_d[i] == i_wb_preg)) s2r_d[i] = 1'b1;
      if (disp_fire && (CW'(i) == wr_slot)) begin
        s1r_d[i] = cap1;
        s2r_d[i] = cap2;
        du_d[i]  = i_dst_used;
        s1p_d[i] = i_src1_preg;
        s2p_d[i] = i_src2_preg;
        dp_d[i]  = i_dst_preg;
        pl_d[i]  = i_payload;
      end
    end
    count_d = i_flush ? '0 : count_q + CW'(disp_fire) - CW'(issue_fire);
  end

  // Flushed producers never write back, so their destinations are released.
  always_comb begin
    sb_d = sb_q;
    if (i_wb_valid) sb_d[i_wb_preg] = 1'b1;
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && du_q[i]) sb_d[dp_q[i]] = 1'b1;
      end
    end
    if (disp_fire && i_dst_used && (i_dst_preg != '0)) sb_d[i_dst_preg] = 1'b0;
    sb_d[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      sb_q    <= '1;
      s1r_q   <= '0;
      s2r_q   <= '0;
      du_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1p_q[i] <= '0;
        s2p_q[i] <= '0;
        dp_q[i]  <= '0;
        pl_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      sb_q    <= sb_d;
      s1r_q   <= s1r_d;
      s2r_q   <= s2r_d;
      du_q    <= du_d;
      for (int i = 0; i < DEPTH; i++) begin
        s1p_q[i] <= s1p_d[i];
        s2p_q[i] <= s2p_d[i];
        dp_q[i]  <= dp_d[i];
        pl_q[i]  <= pl_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sch_issue_queue.sv
// Table-driven bench for sch_issue_queue plus hand sequences for async reset.
module tb_sch_issue_queue;

`ifdef SCH_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 0, i_valid = 0, o_stall;
  logic        i_src1_used = 0, i_src2_used = 0, i_dst_used = 0;
  logic [5:0]  i_src1_preg = 0, i_src2_preg = 0, i_dst_preg = 0;
  logic [95:0] i_payload = 0;
  logic        i_wb_valid = 0;
  logic [5:0]  i_wb_preg = 0;
  logic        o_issue_valid, i_issue_ready = 0;
  logic [5:0]  o_issue_src1_preg, o_issue_src2_preg, o_issue_dst_preg;
  logic        o_issue_dst_used;
  logic [95:0] o_issue_payload;
  logic [3:0]  o_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sch_issue_queue #(.DEPTH(8), .PREG_W(6), .PAYLOAD_W(96)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_stall(o_stall),
    .i_src1_used(i_src1_used), .i_src2_used(i_src2_used), .i_dst_used(i_dst_used),
    .i_src1_preg(i_src1_preg), .i_src2_preg(i_src2_preg), .i_dst_preg(i_dst_preg),
    .i_payload(i_payload), .i_wb_valid(i_wb_valid), .i_wb_preg(i_wb_preg),
    .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
    .o_issue_src1_preg(o_issue_src1_preg), .o_issue_src2_preg(o_issue_src2_preg),
    .o_issue_dst_preg(o_issue_dst_preg), .o_issue_dst_used(o_issue_dst_used),
    .o_issue_payload(o_issue_payload), .o_count(o_count)
  );

  typedef struct {
    bit v; bit s1u; int s1p; bit s2u; int s2p; int dp;
    bit wbv; int wbp; bit rdy; bit fl;
    bit eiv; int edst; int ecnt; bit estall;
  } vec_t;

  vec_t vq[$];

  function automatic logic [95:0] mkpl(int d);
    return {32'hC0DE_0000 + 32'(d), 32'(d * 3 + 1), ~32'(d)};
  endfunction

  function automatic vec_t mk(bit v, bit s1u, int s1p, bit s2u, int s2p, int dp, bit wbv,
                              int wbp, bit rdy, bit fl, bit eiv, int edst, int ecnt);
    vec_t r;
    r.v = v; r.s1u = s1u; r.s1p = s1p; r.s2u = s2u; r.s2p = s2p; r.dp = dp;
    r.wbv = wbv; r.wbp = wbp; r.rdy = rdy; r.fl = fl;
    r.eiv = eiv; r.edst = edst; r.ecnt = ecnt; r.estall = (ecnt == 8);
    return r;
  endfunction

  function automatic vec_t dsp(bit s1u, int s1p, int dp, bit rdy, bit eiv, int edst, int ecnt);
    return mk(1, s1u, s1p, 0, 0, dp, 0, 0, rdy, 0, eiv, edst, ecnt);
  endfunction

  function automatic vec_t idl(bit rdy, bit eiv, int edst, int ecnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, eiv, edst, ecnt);
  endfunction

  function automatic vec_t wbk(int wbp, bit rdy, bit eiv, int edst, int ecnt);
    return mk(0, 0, 0, 0, 0, 0, 1, wbp, rdy, 0, eiv, edst, ecnt);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t e);
    i_valid = e.v; i_src1_used = e.s1u; i_src1_preg = 6'(e.s1p);
    i_src2_used = e.s2u; i_src2_preg = 6'(e.s2p);
    i_dst_used = 1'b1; i_dst_preg = 6'(e.dp); i_payload = mkpl(e.dp);
    i_wb_valid = e.wbv; i_wb_preg = 6'(e.wbp);
    i_issue_ready = e.rdy; i_flush = e.fl;
  endtask

  initial begin
    // Issue/dispatch basics and dependent wakeup
    vq.push_back(dsp(1, 5, 9, 1, 0, 0, 0));
    vq.push_back(idl(1, 1, 9, 1));
    vq.push_back(idl(0, 0, 0, 0));
    vq.push_back(dsp(0, 0, 20, 0, 0, 0, 0));
    vq.push_back(dsp(1, 9, 21, 0, 1, 20, 1));
    vq.push_back(idl(1, 1, 20, 2));
    vq.push_back(idl(1, 0, 0, 1));
    vq.push_back(wbk(9, 1, BYP, 21, 1));
    vq.push_back(idl(1, !BYP, 21, BYP ? 0 : 1));
    vq.push_back(idl(0, 0, 0, 0));
    // Fill to full, then dispatch+issue with a full queue
    for (int k = 0; k < 8; k++) vq.push_back(dsp(0, 0, 30 + k, 0, k > 0, 30, k));
    vq.push_back(dsp(0, 0, 38, 1, 1, 30, 8));
    vq.push_back(idl(0, 1, 31, 7));
    for (int k = 0; k < 7; k++) vq.push_back(idl(1, 1, 31 + k, 7 - k));
    vq.push_back(idl(0, 0, 0, 0));
    // Out-of-order select, then oldest wins once woken
    vq.push_back(dsp(1, 20, 50, 0, 0, 0, 0));
    vq.push_back(dsp(0, 0, 51, 0, 0, 0, 1));
    vq.push_back(dsp(0, 0, 52, 0, 1, 51, 2));
    vq.push_back(idl(1, 1, 51, 3));
    vq.push_back(wbk(20, 0, 1, BYP ? 50 : 52, 2));
    vq.push_back(idl(1, 1, 50, 2));
    vq.push_back(dsp(0, 0, 53, 1, 1, 52, 1));
    vq.push_back(idl(0, 1, 53, 1));
    vq.push_back(idl(1, 1, 53, 1));
    vq.push_back(idl(0, 0, 0, 0));
    // Flush with pending producers and a dropped dispatch
    vq.push_back(dsp(0, 0, 10, 0, 0, 0, 0));
    vq.push_back(dsp(0, 0, 11, 0, 1, 10, 1));
    vq.push_back(dsp(0, 0, 12, 0, 1, 10, 2));
    vq.push_back(mk(1, 0, 0, 0, 0, 13, 0, 0, 1, 1, 1, 10, 3));
    vq.push_back(idl(0, 0, 0, 0));
    vq.push_back(mk(1, 1, 10, 1, 11, 60, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(dsp(1, 12, 61, 0, 1, 60, 1));
    vq.push_back(idl(1, 1, 60, 2));
    vq.push_back(idl(1, 1, 61, 1));
    vq.push_back(idl(0, 0, 0, 0));
    // Writeback coincident with capture
    vq.push_back(dsp(0, 0, 7, 1, 0, 0, 0));
    vq.push_back(idl(1, 1, 7, 1));
    vq.push_back(mk(1, 1, 7, 0, 0, 62, 1, 7, 1, 0, 0, 0, 0));
    vq.push_back(idl(1, 1, 62, 1));
    vq.push_back(idl(0, 0, 0, 0));
    // Same-cycle set and clear of one preg: clear wins
    vq.push_back(mk(1, 0, 0, 0, 0, 25, 1, 25, 0, 0, 0, 0, 0));
    vq.push_back(dsp(1, 25, 63, 0, 1, 25, 1));
    vq.push_back(idl(1, 1, 25, 2));
    vq.push_back(idl(1, 0, 0, 1));
    vq.push_back(wbk(25, 1, BYP, 63, 1));
    vq.push_back(idl(1, !BYP, 63, BYP ? 0 : 1));
    vq.push_back(idl(0, 0, 0, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.iv", o_issue_valid, 0);
    chk("reset.count", o_count, 0);
    chk("reset.stall", o_stall, 0);
    chk("reset.dst", o_issue_dst_preg, 0);
    chk("reset.src1", o_issue_src1_preg, 0);
    chk("reset.payload", o_issue_payload, 0);

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1 apply(vq[k]);
      @(negedge clk);
      chk($sformatf("v%0d.iv", k), o_issue_valid, vq[k].eiv);
      chk($sformatf("v%0d.count", k), o_count, vq[k].ecnt);
      chk($sformatf("v%0d.stall", k), o_stall, vq[k].estall);
      if (vq[k].eiv) begin
        chk($sformatf("v%0d.dst", k), o_issue_dst_preg, vq[k].edst);
        chk($sformatf("v%0d.payload", k), o_issue_payload, mkpl(vq[k].edst));
      end
    end

    // Issue-port index fields, then asynchronous reset mid-cycle
    @(posedge clk);
    #1 apply(mk(1, 1, 9, 1, 0, 44, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 apply(idl(0, 0, 0, 0));
    chk("idx.iv", o_issue_valid, 1);
    chk("idx.src1", o_issue_src1_preg, 9);
    chk("idx.src2", o_issue_src2_preg, 0);
    chk("idx.dst", o_issue_dst_preg, 44);
    chk("idx.dst_used", o_issue_dst_used, 1);
    chk("idx.count", o_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.count", o_count, 0);
    chk("arst.iv", o_issue_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    // Preg 61 was claimed earlier; reset must mark it ready again.
    @(posedge clk);
    #1 apply(dsp(1, 61, 45, 0, 0, 0, 0));
    @(posedge clk);
    #1 apply(idl(0, 0, 0, 0));
    chk("arst.sb_iv", o_issue_valid, 1);
    chk("arst.sb_dst", o_issue_dst_preg, 45);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
